// File: rtl/reg_file_wb.sv
// 32x32 register file with write-through read bypass and a pending-load
// scoreboard that raises StallD on load-use hazards.
module reg_file_wb (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        RegWriteD,
  input  logic [4:0]  WriteAddressD,
  input  logic [31:0] RegInDataD,
  input  logic [4:0]  ReadAddress1,
  input  logic [4:0]  ReadAddress2,
  output logic [31:0] ReadData1,
  output logic [31:0] ReadData2,
  input  logic        IssueValid,
  input  logic [4:0]  IssueRd,
  input  logic        IssueIsLoad,
  input  logic        Flush,
  output logic        StallD,
  output logic [2:0]  PendingCount
);

  logic [31:0] regs [32];
  logic [31:0] pending;
  logic [31:0] pendNext;
  logic        writeEn;
  logic        hazard1;
  logic        hazard2;
  logic        setLoad;

  function automatic logic [2:0] satCount(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (v[i]) n++;
    end
    return (n > 7) ? 3'd7 : 3'(n);
  endfunction

  assign writeEn = RegWriteD && (WriteAddressD != 5'd0);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int unsigned i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (writeEn) begin
      regs[WriteAddressD] <= RegInDataD;
    end
  end

  always_comb begin
    ReadData1 = regs[ReadAddress1];
    if (ReadAddress1 == 5'd0)
      ReadData1 = '0;
    else if (RegWriteD && (WriteAddressD == ReadAddress1))
      ReadData1 = RegInDataD;
  end

  always_comb begin
    ReadData2 = regs[ReadAddress2];
    if (ReadAddress2 == 5'd0)
      ReadData2 = '0;
    else if (RegWriteD && (WriteAddressD == ReadAddress2))
      ReadData2 = RegInDataD;
  end

  // A pending source is not a hazard if its load result is landing this cycle.
  always_comb begin
    hazard1 = (ReadAddress1 != 5'd0) && pending[ReadAddress1] &&
              !(RegWriteD && (WriteAddressD == ReadAddress1));
    hazard2 = (ReadAddress2 != 5'd0) && pending[ReadAddress2] &&
              !(RegWriteD && (WriteAddressD == ReadAddress2));
    StallD  = !RESET && !Flush && IssueValid && (hazard1 || hazard2);
  end

  // Set is applied after clear so a newer in-flight load keeps its bit.
  always_comb begin
    setLoad  = IssueValid && IssueIsLoad && (IssueRd != 5'd0) &&
               !StallD && !Flush && !RESET;
    pendNext = pending;
    if (Flush) begin
      pendNext = '0;
    end else begin
      if (RegWriteD) pendNext[WriteAddressD] = 1'b0;
      if (setLoad)   pendNext[IssueRd]       = 1'b1;
    end
    pendNext[0] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pending      <= '0;
      PendingCount <= '0;
    end else begin
      pending      <= pendNext;
      PendingCount <= satCount(pendNext);
    end
  end

endmodule
